election_controller: RTL
========================

# election_controller

Session controller and booth arbiter for the voting datapath. Several voting booths share one set of per-candidate tally counters. The block sequences the poll through the phases idle, open, tally and done. While the poll is open it grants at most one booth vote per cycle, round-robin, and commits it to saturating counters. After close it scans the counters and reports a winner and a tie flag.

## Interface
Parameters:
- NUM_BOOTHS, 4, number of requesting booths (≥2)
- NUM_CAND, 3, number of candidates (≥2)
- CNT_W, 4, width of each tally counter
- CAND_W, $clog2(NUM_CAND), width of a candidate index (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- open_poll  in  1  level; sampled only in IDLE/DONE
- close_poll  in  1  level; sampled only in OPEN
- booth_req  in  NUM_BOOTHS  per-booth vote request, held until ack/rej
- booth_cand  in  NUM_BOOTHS*CAND_W  candidate index of booth i at bits [i*CAND_W +: CAND_W], stable while req high
- booth_ack  out  NUM_BOOTHS  one-cycle pulse: vote counted
- booth_rej  out  NUM_BOOTHS  one-cycle pulse: vote refused (invalid index)
- poll_state  out  2  0=IDLE 1=OPEN 2=TALLY 3=DONE
- counts  out  NUM_CAND*CNT_W  candidate c at bits [c*CNT_W +: CNT_W]
- sat_flag  out  1  sticky: a vote hit a saturated counter
- winner  out  CAND_W  winning candidate index
- tie  out  1  more than one candidate holds the max count
- result_valid  out  1  high while in DONE

## Operation
- Reset values: state IDLE, all counts 0, rr pointer 0, all ack/rej 0, sat_flag 0, winner 0, tie 0, result_valid 0.
- Transitions:
  - IDLE, open_poll=1: go to OPEN and clear counts and sat_flag at the same edge.
  - OPEN, close_poll=1: go to TALLY.
  - TALLY: stay NUM_CAND cycles, then go to DONE.
  - DONE, open_poll=1: go to OPEN and clear counts, sat_flag, winner and tie.
  - close_poll is ignored outside OPEN. open_poll is ignored in OPEN and TALLY.
- Arbitration (OPEN only, and not in a cycle where close_poll=1):
  - Eligible booth: req=1, and its ack/rej output is 0 this cycle. This blocks double votes from a late-dropped request.
  - Pick the first eligible booth at or after the rr pointer, wrapping. After a grant the pointer becomes grant+1 mod NUM_BOOTHS.
  - Granted booth with valid index (< NUM_CAND): count of that candidate +1, saturating at 2^CNT_W−1; booth_ack pulses the next cycle.
  - Granted booth with invalid index: booth_rej pulses, no count change. The pointer still advances.
  - Vote arriving while its counter is already at max: still acked, and sat_flag is set.
- Requests outside OPEN get no ack or rej and stay pending.
- Tally: a sequential scan over c = 0..NUM_CAND−1, one candidate per cycle, keeping a running max.
  - Strict greater-than replaces winner, so the lowest index wins among equals.
  - An equal count sets tie; a new strict max clears it.
  - All counts zero gives winner=0, tie=1.

## Timing
- Grant decision at edge N (req sampled at N): count updates at N, booth_ack/rej high during cycle N..N+1.
- A booth must drop req in the cycle it sees ack. Vote-to-ack latency is 1 cycle, and throughput is 1 vote/cycle overall.
- close_poll sampled at edge E:
  - state = TALLY after E
  - scan steps at edges E+1..E+NUM_CAND
  - state = DONE and result_valid = 1 after edge E+NUM_CAND
- close_poll and a request in the same cycle: close wins and the request is not granted. It stays pending and is never counted unless the poll reopens.
- counts stay frozen from TALLY through DONE until the next open.
- rst at any cycle, including mid-TALLY or with an ack pending, returns every output to its reset value at that edge.

## Structure
- Package election_pkg holds:
  - the poll_state enum (IDLE, OPEN, TALLY, DONE)
  - default parameter constants
  - a helper function for the saturating increment
- Sub-module rr_arbiter holds the round-robin pointer. Parameter N. Inputs: eligible vector, advance strobe. Outputs: one-hot grant, grant index.
- Counters, FSM and tally scan live in election_controller.

## Test plan
- Reset, open, booth0 votes cand 1 three times → ack each, counts = {0,3,0}. close → result_valid 3 cycles later, winner=1, tie=0.
- All 4 booths request together, every cand 0 → acks on booth 0,1,2,3 in consecutive cycles, count0=4.
- 16 votes for cand 2 with CNT_W=4 → count2=15, sat_flag=1 after 16th ack.
- booth1 requests cand 3 (invalid) → booth_rej[1] pulses, counts unchanged, next booth grant proceeds.
- Counts {2,2,1} then close → winner=0, tie=1. Close with no votes → winner=0, tie=1.
- close_poll asserted the same cycle as booth2 req → no ack, state TALLY. rst mid-TALLY → IDLE, counts 0, result_valid 0.

Source files
------------

// File: rtl/election_pkg.sv
// Shared types, default sizes and helpers for the election controller slice.
package election_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      TALLY = 2'd2,
      DONE  = 2'd3
   } poll_state_t;

   localparam int unsigned DEF_NUM_BOOTHS = 4;
   localparam int unsigned DEF_NUM_CAND   = 3;
   localparam int unsigned DEF_CNT_W      = 4;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : value + 32'd1;
   endfunction

endpackage

// File: rtl/election_controller_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after the pointer wins.
module rr_arbiter
   import election_pkg::*;
#(
   parameter int unsigned N = DEF_NUM_BOOTHS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         eligible,
   input  logic                 advance,
   output logic [N-1:0]         grant_c,
   output logic [$clog2(N)-1:0] grant_idx_c
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx;
   logic             found;

   // Rotating priority search starting at the pointer.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      found       = 1'b0;
      idx         = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDX_W'((32'(ptr) + k) % N);
         if (!found && eligible[idx]) begin
            found        = 1'b1;
            grant_c[idx] = 1'b1;
            grant_idx_c  = idx;
         end
      end
   end

   // Pointer moves just past the last winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx_c == IDX_W'(N - 1)) ? '0 : grant_idx_c + 1'b1;
      end
   end

endmodule

// File: rtl/election_controller.sv
// Poll session FSM, booth vote arbitration, saturating tallies and winner scan.
module election_controller
   import election_pkg::*;
#(
   parameter int unsigned NUM_BOOTHS = DEF_NUM_BOOTHS,
   parameter int unsigned NUM_CAND   = DEF_NUM_CAND,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned CAND_W     = $clog2(NUM_CAND)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         open_poll,
   input  logic                         close_poll,
   input  logic [NUM_BOOTHS-1:0]        booth_req,
   input  logic [NUM_BOOTHS*CAND_W-1:0] booth_cand,
   output logic [NUM_BOOTHS-1:0]        booth_ack,
   output logic [NUM_BOOTHS-1:0]        booth_rej,
   output logic [1:0]                   poll_state,
   output logic [NUM_CAND*CNT_W-1:0]    counts,
   output logic                         sat_flag,
   output logic [CAND_W-1:0]            winner,
   output logic                         tie,
   output logic                         result_valid
);

   localparam int unsigned BIDX_W = $clog2(NUM_BOOTHS);

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_OPEN  = 2'(OPEN);
   localparam logic [1:0] ST_TALLY = 2'(TALLY);
   localparam logic [1:0] ST_DONE  = 2'(DONE);

   logic [1:0]            state, state_nxt;
   logic [CAND_W-1:0]     scan_idx;
   logic [CNT_W-1:0]      cnt [NUM_CAND];
   logic [CNT_W-1:0]      max_cnt;

   logic                  arb_en_c;
   logic [NUM_BOOTHS-1:0] eligible_c;
   logic [NUM_BOOTHS-1:0] grant_c;
   logic [BIDX_W-1:0]     grant_idx_c;
   logic [CAND_W-1:0]     grant_cand_c;
   logic                  grant_any_c;
   logic                  cand_ok_c;
   logic                  open_go_c;
   logic                  close_go_c;

   // Vote qualification; a booth acked/refused this cycle cannot win again.
   always_comb begin
      arb_en_c     = (state == ST_OPEN) && !close_poll;
      eligible_c   = arb_en_c ? (booth_req & ~booth_ack & ~booth_rej) : '0;
      grant_any_c  = |grant_c;
      grant_cand_c = booth_cand[32'(grant_idx_c) * CAND_W +: CAND_W];
      cand_ok_c    = 32'(grant_cand_c) < NUM_CAND;
      open_go_c    = ((state == ST_IDLE) || (state == ST_DONE)) && open_poll;
      close_go_c   = (state == ST_OPEN) && close_poll;
   end

   rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .eligible    (eligible_c),
      .advance     (grant_any_c),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c)
   );

   // Poll state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Poll phase sequencing; tally lasts exactly one cycle per candidate.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (open_poll)  state_nxt = ST_OPEN;
         ST_OPEN:  if (close_poll) state_nxt = ST_TALLY;
         ST_TALLY: if (scan_idx == CAND_W'(NUM_CAND - 1)) state_nxt = ST_DONE;
         ST_DONE:  if (open_poll)  state_nxt = ST_OPEN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign poll_state = state;

   // Result valid tracks DONE, registered off the next state.
   always_ff @(posedge clk) begin
      if (rst) result_valid <= 1'b0;
      else     result_valid <= (state_nxt == ST_DONE);
   end

   // Booth handshake pulses for the vote granted this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         booth_ack <= '0;
         booth_rej <= '0;
      end else begin
         booth_ack <= (grant_any_c && cand_ok_c)  ? grant_c : '0;
         booth_rej <= (grant_any_c && !cand_ok_c) ? grant_c : '0;
      end
   end

   // Saturating tallies, cleared when a new poll opens.
   always_ff @(posedge clk) begin
      if (rst || open_go_c) begin
         for (int unsigned c = 0; c < NUM_CAND; c++) cnt[c] <= '0;
         sat_flag <= 1'b0;
      end else if (grant_any_c && cand_ok_c) begin
         cnt[grant_cand_c] <= CNT_W'(sat_inc(32'(cnt[grant_cand_c]), CNT_W));
         if (cnt[grant_cand_c] == '1) sat_flag <= 1'b1;
      end
   end

   // Winner scan: strict greater replaces, equal marks a tie.
   always_ff @(posedge clk) begin
      if (rst || close_go_c) begin
         scan_idx <= '0;
         max_cnt  <= '0;
         winner   <= '0;
         tie      <= 1'b0;
      end else if (state == ST_TALLY) begin
         scan_idx <= scan_idx + 1'b1;
         if (cnt[scan_idx] > max_cnt) begin
            max_cnt <= cnt[scan_idx];
            winner  <= scan_idx;
            tie     <= 1'b0;
         end else if (cnt[scan_idx] == max_cnt) begin
            tie <= 1'b1;
         end
      end else if (open_go_c) begin
         winner <= '0;
         tie    <= 1'b0;
      end
   end

   // Flatten the tally array onto the counts bus.
   for (genvar c = 0; c < NUM_CAND; c++) begin : g_counts
      assign counts[c*CNT_W +: CNT_W] = cnt[c];
   end

endmodule
